// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - multi-cycle adder/subtractor, BITS_PER_CYCLE bits per clock, LSB first
// Operands are captured on start; sum/cout/ovf are registered on entry to DONE and held.
module serial_addsub #(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int BPC   = BITS_PER_CYCLE;
  localparam int N     = WIDTH / BPC;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  generate
    if (WIDTH < 2 || BPC < 1 || BPC > WIDTH || (WIDTH % BPC) != 0) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and divisible by BITS_PER_CYCLE");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [BPC:0]     w_slice;
  logic             w_msb_cin;
  logic [WIDTH-1:0] w_acc_next;

  assign w_accept = start && (r_state != S_RUN);
  assign w_last   = (r_cnt == LAST);
  assign w_slice  = {1'b0, r_a[BPC-1:0]} + {1'b0, r_b[BPC-1:0]} + {{BPC{1'b0}}, r_carry};
  // Carry into the slice MSB recovered from its sum bit, so no separate low-part adder is needed.
  assign w_msb_cin = w_slice[BPC-1] ^ r_a[BPC-1] ^ r_b[BPC-1];

  generate
    if (BPC == WIDTH) begin : g_single_slice
      assign w_acc_next = w_slice[BPC-1:0];
    end else begin : g_multi_slice
      assign w_acc_next = {w_slice[BPC-1:0], r_acc[WIDTH-1:BPC]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_RUN: begin
          r_a     <= r_a >> BPC;
          r_b     <= r_b >> BPC;
          r_carry <= w_slice[BPC];
          r_acc   <= w_acc_next;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_state <= S_DONE;
            r_sum   <= w_acc_next;
            r_cout  <= w_slice[BPC];
            r_ovf   <= w_msb_cin ^ w_slice[BPC];
          end
        end
        default: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - self-checking bench for serial_addsub
// Four instances (8/1, 4/1, 4/2, 4/4) are compared every cycle against an arithmetic model.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       st0, cin0, sub0;
  logic [7:0] a0, b0;
  logic       st1, cin1, sub1;
  logic [3:0] a1, b1;

  logic       busy_v [4];
  logic       done_v [4];
  logic       cout_v [4];
  logic       ovf_v  [4];
  logic [7:0] d_sum  [4];
  logic [7:0] s0;
  logic [3:0] s1, s2, s3;

  int errors = 0;
  int checks = 0;
  int n_edges = 0;

  int nn [4] = '{8, 4, 2, 1};
  int ww [4] = '{8, 4, 4, 4};
  int age [4];
  int cap_a [4], cap_b [4], cap_cin [4], cap_sub [4];
  int e_sum [4];
  bit e_cout [4], e_ovf [4];

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st0), .a(a0), .b(b0), .cin(cin0), .sub(sub0),
    .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .cout(cout_v[0]), .ovf(ovf_v[0]));
  serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .cout(cout_v[1]), .ovf(ovf_v[1]));
  serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .cout(cout_v[2]), .ovf(ovf_v[2]));
  serial_addsub #(.WIDTH(4), .BITS_PER_CYCLE(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st1), .a(a1), .b(b1), .cin(cin1), .sub(sub1),
    .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .cout(cout_v[3]), .ovf(ovf_v[3]));

  assign d_sum[0] = s0;
  assign d_sum[1] = {4'b0, s1};
  assign d_sum[2] = {4'b0, s2};
  assign d_sum[3] = {4'b0, s3};

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s[%0d] t=%0t got=%0h exp=%0h", nm, idx, $time, act, exp);
    end
  endtask

  // Plain integer arithmetic: unsigned result/carry/borrow and signed range test.
  function automatic void golden(input int w, input int a, input int b, input int cin,
                                 input int sub, output int s, output bit c, output bit o);
    int m, half, sa, sb, r;
    m    = (1 << w) - 1;
    half = 1 << (w - 1);
    sa   = (a >= half) ? a - (1 << w) : a;
    sb   = (b >= half) ? b - (1 << w) : b;
    if (sub != 0) begin
      s = (a - b - cin) & m;
      c = (a >= b + cin);
      r = sa - sb - cin;
    end else begin
      s = (a + b + cin) & m;
      c = ((a + b + cin) > m);
      r = sa + sb + cin;
    end
    o = (r > half - 1) || (r < -half);
  endfunction

  // age = clock edges since the accepting edge; -1 when nothing is in flight.
  always @(posedge clk) begin
    n_edges <= n_edges + 1;
    for (int i = 0; i < 4; i++) begin
      int ag, gs;
      bit was_busy, s, gc, go;
      if (!rst_n) begin
        age[i]    <= -1;
        e_sum[i]  <= 0;
        e_cout[i] <= 1'b0;
        e_ovf[i]  <= 1'b0;
      end else begin
        ag = age[i];
        was_busy = (ag >= 0) && (ag < nn[i]);
        if (ag >= 0) ag++;
        if (ag == nn[i]) begin
          golden(ww[i], cap_a[i], cap_b[i], cap_cin[i], cap_sub[i], gs, gc, go);
          e_sum[i]  <= gs;
          e_cout[i] <= gc;
          e_ovf[i]  <= go;
        end
        if (ag > nn[i]) ag = -1;
        s = (i == 0) ? st0 : st1;
        if (!was_busy && s) begin
          ag = 0;
          cap_a[i]   <= (i == 0) ? int'(a0) : int'(a1);
          cap_b[i]   <= (i == 0) ? int'(b0) : int'(b1);
          cap_cin[i] <= (i == 0) ? int'(cin0) : int'(cin1);
          cap_sub[i] <= (i == 0) ? int'(sub0) : int'(sub1);
        end
        age[i] <= ag;
      end
    end
  end

  always @(negedge clk) begin
    if (n_edges > 0) begin
      for (int i = 0; i < 4; i++) begin
        chk("busy", i, int'(busy_v[i]), (age[i] >= 0 && age[i] < nn[i]) ? 1 : 0);
        chk("done", i, int'(done_v[i]), (age[i] == nn[i]) ? 1 : 0);
        chk("sum",  i, int'(d_sum[i]), e_sum[i]);
        chk("cout", i, int'(cout_v[i]), int'(e_cout[i]));
        chk("ovf",  i, int'(ovf_v[i]), int'(e_ovf[i]));
      end
    end
  end

  task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input bit poke, input int es, input int ec,
                      input int eo, input string nm);
    int k;
    a0 = a; b0 = b; cin0 = cin; sub0 = sub; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    k = 0;
    while (!done_v[0] && k < 40) begin
      @(negedge clk);
      k++;
      if (poke && k == 3) begin
        st0 = 1'b1; a0 = ~a; sub0 = ~sub;
      end else if (poke && k == 4) begin
        st0 = 1'b0;
      end
    end
    chk({nm, "_latency"}, 0, k, 8);
    chk({nm, "_sum"}, 0, int'(s0), es);
    chk({nm, "_cout"}, 0, int'(cout_v[0]), ec);
    chk({nm, "_ovf"}, 0, int'(ovf_v[0]), eo);
  endtask

  initial begin
    int k, gap, ndone;
    rst_n = 1'b0;
    st0 = 1'b1; a0 = 8'hA5; b0 = 8'h5A; cin0 = 1'b1; sub0 = 1'b0;
    st1 = 1'b1; a1 = 4'h9; b1 = 4'h3; cin1 = 1'b0; sub1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 0, int'(busy_v[0]), 0);
    chk("rst_done", 0, int'(done_v[0]), 0);
    chk("rst_sum",  0, int'(s0), 0);
    chk("rst_cout", 0, int'(cout_v[0]), 0);
    chk("rst_ovf",  0, int'(ovf_v[0]), 0);
    rst_n = 1'b1; st0 = 1'b0; st1 = 1'b0;
    @(negedge clk);

    run0(8'hFF, 8'h01, 1'b0, 1'b0, 1'b0, 8'h00, 1, 0, "add_wrap");
    run0(8'h05, 8'h07, 1'b0, 1'b1, 1'b0, 8'hFE, 0, 0, "sub_borrow");
    run0(8'h80, 8'h01, 1'b0, 1'b1, 1'b0, 8'h7F, 1, 1, "sub_ovf");
    run0(8'h3C, 8'h0F, 1'b1, 1'b0, 1'b1, 8'h4C, 0, 0, "poke_ignored");
    repeat (12) @(negedge clk);

    a0 = 8'h12; b0 = 8'h34; cin0 = 1'b0; sub0 = 1'b0; st0 = 1'b1;
    k = 0;
    while (!done_v[0] && k < 40) begin
      @(negedge clk);
      k++;
    end
    for (int p = 0; p < 2; p++) begin
      gap = 0;
      do begin
        @(negedge clk);
        gap++;
      end while (!done_v[0] && gap < 40);
      chk("b2b_gap", p, gap, 9);
      chk("b2b_sum", p, int'(s0), 8'h46);
    end
    st0 = 1'b0;
    repeat (12) @(negedge clk);

    a0 = 8'h55; b0 = 8'h22; st0 = 1'b1;
    @(negedge clk);
    st0 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 0, int'(busy_v[0]), 0);
    chk("abort_done", 0, int'(done_v[0]), 0);
    chk("abort_sum",  0, int'(s0), 0);
    rst_n = 1'b1;
    ndone = 0;
    repeat (12) begin
      @(negedge clk);
      if (done_v[0]) ndone++;
    end
    chk("abort_no_done", 0, ndone, 0);

    for (int sb = 0; sb < 2; sb++)
      for (int ci = 0; ci < 2; ci++)
        for (int ia = 0; ia < 16; ia++)
          for (int ib = 0; ib < 16; ib++) begin
            a1 = 4'(ia); b1 = 4'(ib); cin1 = 1'(ci); sub1 = 1'(sb); st1 = 1'b1;
            @(negedge clk);
            st1 = 1'b0;
            repeat (3) @(negedge clk);
          end
    repeat (4) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog t=%0t got=timeout exp=finish", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
